// File: rtl/mem_arbiter.sv
// Two-requester (I/D) arbiter and sequencer for one slow ack-handshake memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate priority on simultaneous requests.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] i_dout,
  output logic                  i_stall,
  output logic                  i_ack,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_ren,
  input  logic                  d_wen,
  input  logic [DATA_WIDTH-1:0] d_din,
  output logic [DATA_WIDTH-1:0] d_dout,
  output logic                  d_stall,
  output logic                  d_ack,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_ren,
  output logic                  m_wen,
  output logic                  m_cs,
  output logic [DATA_WIDTH-1:0] m_din,
  input  logic [DATA_WIDTH-1:0] m_dout,
  input  logic                  m_ack,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] i_dout_q, i_dout_d;
  logic [DATA_WIDTH-1:0] d_dout_q, d_dout_d;
  logic [7:0]            cnt_q, cnt_d;

  logic d_req;
  logic grant_d;
  logic timeout;

  assign d_req   = d_ren | d_wen;
  assign timeout = (state_q == BUSY) & ~m_ack & (cnt_q == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  // owner encoding: 1 = D. Reset to D so that I wins the first tie.
  logic last_grant_q, last_grant_d;

  // Winner selection: a lone requester wins, a tie goes to the other side
  always_comb begin
    grant_d      = d_req & (~i_ren | ~last_grant_q);
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) & (d_req | i_ren))
      last_grant_d = grant_d;
  end

  // Remember the side granted last
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority, D over I
  assign grant_d = d_req;
`endif

  // State and transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      i_dout_q <= '0;
      d_dout_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      i_dout_q <= i_dout_d;
      d_dout_q <= d_dout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: grant in IDLE, wait for ack or timeout in BUSY, one DONE cycle
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    din_d    = din_q;
    i_dout_d = i_dout_q;
    d_dout_d = d_dout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (d_req | i_ren) begin
          state_d = BUSY;
          owner_d = grant_d;
          op_wr_d = grant_d & d_wen;
          addr_d  = grant_d ? d_addr : i_addr;
          din_d   = grant_d ? d_din : din_q;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (m_ack) begin
          state_d = DONE;
          if (owner_q) d_dout_d = m_dout;
          else         i_dout_d = m_dout;
        end else if (timeout) begin
          state_d = DONE;
          if (owner_q) d_dout_d = '0;
          else         i_dout_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: strobes drop with m_ack so the memory does not restart
  always_comb begin
    m_cs  = (state_q == BUSY);
    m_ren = m_cs & ~op_wr_q & ~m_ack;
    m_wen = m_cs & op_wr_q & ~m_ack;
    err   = timeout;
    i_ack = (state_q == DONE) & ~owner_q & i_ren;
    d_ack = (state_q == DONE) & owner_q & d_req;
  end

  assign i_stall = i_ren & ~i_ack;
  assign d_stall = d_req & ~d_ack;
  assign m_addr  = addr_q;
  assign m_din   = din_q;
  assign i_dout  = i_dout_q;
  assign d_dout  = d_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: slow-memory model plus ack scoreboard.
// Defining ARB_ROUND_ROBIN_EN flips the expected tie order.
module tb_mem_arbiter;

  logic        clk, rst;
  logic [31:0] i_addr, i_dout;
  logic        i_ren, i_stall, i_ack;
  logic [31:0] d_addr, d_din, d_dout;
  logic        d_ren, d_wen, d_stall, d_ack;
  logic [31:0] m_addr, m_din, m_dout;
  logic        m_ren, m_wen, m_cs, m_ack, err;

  mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_ren(i_ren), .i_dout(i_dout),
    .i_stall(i_stall), .i_ack(i_ack),
    .d_addr(d_addr), .d_ren(d_ren), .d_wen(d_wen),
    .d_din(d_din), .d_dout(d_dout),
    .d_stall(d_stall), .d_ack(d_ack),
    .m_addr(m_addr), .m_ren(m_ren), .m_wen(m_wen),
    .m_cs(m_cs), .m_din(m_din), .m_dout(m_dout),
    .m_ack(m_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          side;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   err_cnt = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory model: m_ack is high in the lat-th BUSY cycle
  logic [31:0] mem [0:255];
  int          lat = 8;
  int          mcnt;
  bit          mem_hang = 0;

  always @(posedge clk) begin
    if (rst || !m_cs) begin
      m_ack <= 1'b0;
      mcnt  <= 0;
    end else if (m_ack) begin
      m_ack <= 1'b0;
    end else if (!mem_hang && mcnt == lat - 2) begin
      m_ack  <= 1'b1;
      m_dout <= mem[m_addr[9:2]];
      if (m_wen) mem[m_addr[9:2]] <= m_din;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  // scoreboard: every requester ack pops one expectation
  always @(negedge clk) begin
    if (!rst && (i_ack || d_ack)) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {i_ack, d_ack}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_side", {i_ack, d_ack}, e.side ? 2'b01 : 2'b10);
        if (e.chk)
          check("rdata", e.side ? d_dout : i_dout, e.data);
      end
    end
    if (!rst && err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit side, input bit chk,
                      input logic [31:0] data);
    exp_t e;
    e.side = side;
    e.chk  = chk;
    e.data = data;
    sb.push_back(e);
  endtask

  // run until all requests are acked and dropped
  task automatic run(input int max);
    bit di, dd;
    int n;
    di = 0;
    dd = 0;
    n  = 0;
    while ((i_ren || d_ren || d_wen) && n < max) begin
      tick();
      n++;
      if (di) i_ren = 1'b0;
      if (dd) begin
        d_ren = 1'b0;
        d_wen = 1'b0;
      end
      #1;
      if (i_ack || d_ack)
        check("done_strobes", {m_cs, m_ren, m_wen}, 0);
      if (i_ack) di = 1;
      if (d_ack) dd = 1;
    end
    check("run_budget", n >= max, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[1] = 32'h1234_5678;
    rst = 1'b1;
    i_addr = '0; i_ren = 0;
    d_addr = '0; d_ren = 0; d_wen = 0; d_din = '0;
    repeat (3) tick();
    check("rst_m", {m_ren, m_wen, m_cs, err}, 0);
    check("rst_ack", {i_ack, d_ack, i_stall, d_stall}, 0);
    check("rst_dout", {i_dout, d_dout}, 0);
    check("rst_mbus", {m_addr, m_din}, 0);
    rst = 1'b0;
    tick();

    // single I read, latency 8
    lat = 8;
    i_addr = 32'h4;
    i_ren  = 1'b1;
    push(0, 1, 32'h1234_5678);
    #1;
    check("t1_stall0", i_stall, 1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("t1_mren", m_ren, (c <= 7));
      check("t1_iack", i_ack, (c == 9));
      check("t1_istall", i_stall, (c <= 8));
      if (c <= 8) check("t1_maddr", m_addr, 32'h4);
    end
    tick();
    i_ren = 1'b0;
    #1;
    check("t1_idle", m_cs, 0);

    // D write, latency 4, inputs change mid-flight
    tick();
    lat = 4;
    d_addr = 32'h10;
    d_din  = 32'hDEAD_BEEF;
    d_wen  = 1'b1;
    push(1, 0, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) begin
        d_addr = 32'h99;
        d_din  = 32'h0;
        #1;
      end
      check("t2_mren", m_ren, 0);
      check("t2_mwen", m_wen, (c <= 3));
      check("t2_dack", d_ack, (c == 5));
      if (c <= 4) begin
        check("t2_maddr", m_addr, 32'h10);
        check("t2_mdin", m_din, 32'hDEAD_BEEF);
      end
    end
    tick();
    d_wen = 1'b0;

    // simultaneous reads; D read returns the earlier write
    tick();
    i_addr = 32'h8;
    i_ren  = 1'b1;
    d_addr = 32'h10;
    d_ren  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    push(0, 1, 32'hC0DE_0002);
    push(1, 1, 32'hDEAD_BEEF);
`else
    push(1, 1, 32'hDEAD_BEEF);
    push(0, 1, 32'hC0DE_0002);
`endif
    run(60);

    // timeout: memory never acks
    tick();
    mem_hang = 1;
    begin
      int base;
      base = err_cnt;
      i_addr = 32'h20;
      i_ren  = 1'b1;
      push(0, 1, 32'h0);
      for (int c = 1; c <= 17; c++) begin
        tick();
        check("t4_err", err, (c == 16));
        check("t4_iack", i_ack, (c == 17));
        check("t4_mren", m_ren, (c <= 16));
      end
      tick();
      i_ren = 1'b0;
      #1;
      check("t4_idle", m_cs, 0);
      tick();
      check("t4_still_idle", m_cs, 0);
      check("t4_err_cnt", err_cnt - base, 1);
    end
    mem_hang = 0;

    // D read dropped mid-flight, pending I served next
    lat = 4;
    d_addr = 32'h10;
    d_ren  = 1'b1;
    tick();
    i_addr = 32'h4;
    i_ren  = 1'b1;
    tick();
    d_ren = 1'b0;
    #1;
    check("t5_dstall", d_stall, 0);
    check("t5_istall", i_stall, 1);
    push(0, 1, 32'h1234_5678);
    run(60);

    // reset in the middle of a read
    tick();
    lat = 8;
    i_addr = 32'h4;
    i_ren  = 1'b1;
    push(0, 1, 32'h1234_5678);
    tick();
    tick();
    tick();
    check("t6_busy", {m_cs, m_ren}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_mport", {m_cs, m_ren, m_wen}, 0);
    check("t6_acks", {i_ack, d_ack, err}, 0);
    check("t6_douts", {i_dout, d_dout}, 0);
    run(60);

    tick();
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
